// File: rtl/spi_master.sv
//------------------------------------------------------------------------------
// Module   : spi_master
// Purpose  : SPI mode-0 master, one DATA_WIDTH-bit MSB-first word per start.
//            Define SPI_MASTER_SOMI_SYNC_EN to add a 2-flop SOMI synchronizer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module spi_master #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_datain,
  input  logic                  SOMI,
  output logic                  SIMO,
  output logic                  SCLK,
  output logic                  cs,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rx_dataout
);

  localparam int c_DIV_W = $clog2(CLK_DIV);
  localparam int c_BIT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_XFER  = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t                r_state;
  logic [c_DIV_W-1:0]    r_div;
  logic [c_BIT_W-1:0]    r_bit;
  logic [DATA_WIDTH-2:0] r_tx;    // bits still to send after the one on SIMO
  logic [DATA_WIDTH-1:0] r_rx;
  logic                  w_somi;
  logic                  w_div_end;

`ifdef SPI_MASTER_SOMI_SYNC_EN
  logic r_somi_s1;
  logic r_somi_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_somi_s1 <= 1'b0;
      r_somi_s2 <= 1'b0;
    end else begin
      r_somi_s1 <= SOMI;
      r_somi_s2 <= r_somi_s1;
    end
  end

  assign w_somi = r_somi_s2;
`else
  assign w_somi = SOMI;
`endif

  assign w_div_end = (r_div == c_DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_div      <= '0;
      r_bit      <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      SIMO       <= 1'b0;
      SCLK       <= 1'b0;
      cs         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      rx_dataout <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          cs    <= 1'b1;
          SCLK  <= 1'b0;
          r_div <= '0;
          if (start) begin
            r_tx    <= tx_datain[DATA_WIDTH-2:0];
            SIMO    <= tx_datain[DATA_WIDTH-1];
            r_rx    <= '0;
            r_bit   <= c_BIT_W'(DATA_WIDTH);
            cs      <= 1'b0;
            busy    <= 1'b1;
            r_state <= S_SETUP;
          end
        end

        // The edge that raises SCLK is also the one that captures SOMI.
        S_SETUP: begin
          if (w_div_end) begin
            r_div   <= '0;
            SCLK    <= 1'b1;
            r_rx    <= {r_rx[DATA_WIDTH-2:0], w_somi};
            r_bit   <= r_bit - c_BIT_W'(1);
            r_state <= S_XFER;
          end else begin
            r_div <= r_div + c_DIV_W'(1);
          end
        end

        S_XFER: begin
          if (w_div_end) begin
            r_div <= '0;
            if (SCLK) begin
              SCLK <= 1'b0;
              if (r_bit == '0) begin
                r_state <= S_HOLD;
              end else begin
                SIMO <= r_tx[DATA_WIDTH-2];
                r_tx <= r_tx << 1;
              end
            end else begin
              SCLK  <= 1'b1;
              r_rx  <= {r_rx[DATA_WIDTH-2:0], w_somi};
              r_bit <= r_bit - c_BIT_W'(1);
            end
          end else begin
            r_div <= r_div + c_DIV_W'(1);
          end
        end

        S_HOLD: begin
          if (w_div_end) begin
            r_div      <= '0;
            cs         <= 1'b1;
            rx_dataout <= r_rx;
            done       <= 1'b1;
            r_state    <= S_GAP;
          end else begin
            r_div <= r_div + c_DIV_W'(1);
          end
        end

        S_GAP: begin
          if (w_div_end) begin
            r_div   <= '0;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_div <= r_div + c_DIV_W'(1);
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_div   <= '0;
          cs      <= 1'b1;
          SCLK    <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/spi_master.md
# spi_master

SPI mode-0 (CPOL=0, CPHA=0) master that generates `cs`, `SCLK` and `SIMO` and captures `SOMI`, transferring one DATA_WIDTH-bit word MSB-first per `start` request. It sits directly upstream of `spi_slave` in the off-chip SPI path and drives its serial pins. The host side is a single-cycle start/done handshake with parallel transmit and receive words.

## Interface
- DATA_WIDTH, 8: bits per frame, ≥2.
- CLK_DIV, 4: `clk` cycles per SCLK half-period. Minimum is 4, or 6 with SPI_MASTER_SOMI_SYNC_EN.
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request; accepted only when `busy`=0.
- tx_datain  input  DATA_WIDTH  word to transmit; captured on the accepting cycle.
- SOMI  input  1  serial data from slave.
- SIMO  output  1  serial data to slave; MSB first.
- SCLK  output  1  serial clock; idles low.
- cs  output  1  chip select, active low.
- busy  output  1  high from the cycle after acceptance until the inter-frame gap ends.
- done  output  1  one-cycle pulse when `rx_dataout` updates.
- rx_dataout  output  DATA_WIDTH  last received word; holds until the next `done`.

## Operation
- States:
  - IDLE: `cs`=1, `SCLK`=0. On `start`=1: load tx_shift←`tx_datain`, clear rx_shift, go to SETUP.
  - SETUP: `cs`=0, `SIMO`=tx_shift MSB. Count CLK_DIV cycles, then set `SCLK`=1, go to XFER.
  - XFER: toggle `SCLK` every CLK_DIV cycles.
    - Each rising edge: rx_shift←{rx_shift[DATA_WIDTH-2:0], SOMI} and decrement bit counter.
    - Each falling edge except the last: shift tx_shift left and drive the new MSB on `SIMO`.
    - After the DATA_WIDTH-th falling edge (`SCLK`=0), go to HOLD.
  - HOLD: `cs` stays low for CLK_DIV cycles. Then `cs`←1, `rx_dataout`←rx_shift, `done`←1, go to GAP.
  - GAP: `cs`=1 for CLK_DIV cycles, then `busy`←0 and go to IDLE.
- Bit counter width is $clog2(DATA_WIDTH)+1. The half-period counter counts 0..CLK_DIV-1 and wraps.
- `start` while `busy`=1 is ignored, with no queueing. `tx_datain` is don't-care outside the accepting cycle.
- Default state returns to IDLE.
- Reset at any point, including mid-frame, forces these outputs immediately (asynchronously): `cs`=1, `SCLK`=0, `SIMO`=0, `busy`=0, `done`=0, `rx_dataout`=0, state IDLE. The partial frame is discarded.
- The SETUP and HOLD windows exist so that `spi_slave` preloads its MSB after `cs` falls and latches its receive word after `cs` rises. The GAP window guarantees `cs` is high long enough for the slave to reload its transmit word.

## Timing
- Cycle 0 is the cycle with `start` sampled high in IDLE; N=DATA_WIDTH, D=CLK_DIV.
- Cycle 1: `busy`=1, `cs`=0, `SIMO`=tx MSB.
- First SCLK rise at cycle 1+D; rises at 1+D+2kD and falls at 1+2D+2kD, for k=0..N-1.
- `SIMO` changes only on falling-edge cycles. It is stable for ≥D cycles around every rising edge.
- `cs`↑, `done`=1 and `rx_dataout` valid at cycle 1+(2N+1)D. `busy`↓ at cycle 1+(2N+2)D.
- Defaults (N=8, D=4): first rise at cycle 5, `done` at cycle 69, `busy` low at cycle 73.
- The next `start` is accepted in the cycle where `busy` reads 0. The minimum `cs`-high gap between frames is D+1 cycles.

## Configuration
- SPI_MASTER_SOMI_SYNC_EN defined: `SOMI` passes through a 2-flop synchronizer before the rx shift register.
  - The rising-edge capture samples the synchronized value.
  - All frame timing above is unchanged.
  - CLK_DIV must be ≥6.
- Undefined: `SOMI` is sampled directly in the rising-edge cycle; CLK_DIV ≥4.

## Test plan
- Loopback (`SOMI` tied to `SIMO`), `tx_datain`=8'hA5, D=4 -> `done` pulse at cycle 69, `rx_dataout`=8'hA5, exactly 8 SCLK rising edges.
- Master connected to spi_slave: master tx 8'h3C, slave tx 8'hC3 -> master `rx_dataout`=8'hC3, slave rx 8'h3C, both `done` asserted.
- `start` pulsed again at cycle 20 with `tx_datain`=8'hFF -> ignored; frame completes with the original data and only one `done` occurs.
- `rst_n` low at cycle 30 mid-frame -> `cs`=1, `SCLK`=0, `busy`=0 immediately; a new `start` afterwards completes a clean 8'h5A loopback frame.
- `SOMI` held at 1 and `start` pulsed at cycle 73 right after a previous frame -> second frame gives `rx_dataout`=8'hFF, and `cs` stays high ≥5 cycles between frames.
- SPI_MASTER_SOMI_SYNC_EN defined, D=6, loopback tx 8'h81 -> `rx_dataout`=8'h81 and `done` at cycle 1+17·6=103.
